banked_fmap_ram: RTL and testbench

- Parametrised multi-bank feature-map buffer: NUM_BANKS independent simple-dual-port banks, one write port and one read port per bank, usable in the same cycle.
- Adds a configurable read latency with a per-bank valid pipeline, a selectable read-during-write mode, and a hardware clear engine that zero-fills all banks.
- Sits between conv output stages and the max-pool/next-layer readers as the inter-layer activation store.

---
 rtl/banked_fmap_ram.sv | 137 +++++++++++++
 tb/tb_banked_fmap_ram.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_fmap_ram.sv
// Multi-bank simple-dual-port activation buffer with configurable read latency,
// selectable read-during-write behaviour and a zero-fill clear engine.
module banked_fmap_ram #(
    parameter int NUM_BANKS     = 128,
    parameter int A_WID         = 7,
    parameter int D_WID         = 20,
    parameter int RD_LAT        = 1,
    parameter int WR_MODE       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic [NUM_BANKS-1:0]    wr_en,
    input  logic [A_WID-1:0]        wr_addr [NUM_BANKS],
    input  logic signed [D_WID-1:0] wr_data [NUM_BANKS],
    input  logic [NUM_BANKS-1:0]    rd_en,
    input  logic [A_WID-1:0]        rd_addr [NUM_BANKS],
    output logic signed [D_WID-1:0] rd_data [NUM_BANKS],
    output logic [NUM_BANKS-1:0]    rd_valid
);

    localparam int DEPTH = 2 ** A_WID;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? CLEAR : IDLE;

    state_t           state_q, state_d;
    logic [A_WID-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             clearing;

    assign clearing = (state_q == CLEAR);
    assign busy     = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            busy_q  <= (INIT_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic signed [D_WID-1:0] mem [DEPTH];
        logic signed [D_WID-1:0] s1_data_q, s1_data_d;
        logic                    s1_valid_q, s1_valid_d;
        logic                    collide;

        // Storage is deliberately outside reset; the clear engine owns zero-filling.
        always_ff @(posedge clk) begin
            if (clearing) begin
                mem[cnt_q] <= '0;
            end else if (wr_en[b]) begin
                mem[wr_addr[b]] <= wr_data[b];
            end
        end

        assign collide = (WR_MODE != 0) && wr_en[b] && (wr_addr[b] == rd_addr[b]);

        always_comb begin
            s1_valid_d = rd_en[b] && !clearing;
            s1_data_d  = s1_data_q;
            if (s1_valid_d) begin
                s1_data_d = collide ? wr_data[b] : mem[rd_addr[b]];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_data_q  <= s1_data_d;
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic signed [D_WID-1:0] s2_data_q, s2_data_d;
            logic                    s2_valid_q, s2_valid_d;

            // Second stage keeps advancing during a clear so in-flight reads drain.
            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign rd_valid[b] = s2_valid_q;
            assign rd_data[b]  = s2_data_q;
        end else begin : g_lat1
            assign rd_valid[b] = s1_valid_q;
            assign rd_data[b]  = s1_data_q;
        end
    end

endmodule

// File: tb/tb_banked_fmap_ram.sv
// Directed bench for banked_fmap_ram: two instances (RD_LAT=1/read-first and
// RD_LAT=2/write-first) share the same stimulus and are checked against hand values.
module tb_banked_fmap_ram;

    localparam int NB = 4;
    localparam int AW = 4;
    localparam int DW = 20;

    logic                 clock;
    logic                 rstN;
    logic                 clrReq;
    logic [NB-1:0]        wrEn;
    logic [AW-1:0]        wrAddr [NB];
    logic signed [DW-1:0] wrData [NB];
    logic [NB-1:0]        rdEn;
    logic [AW-1:0]        rdAddr [NB];

    logic                 busyA, busyB;
    logic signed [DW-1:0] rdDataA [NB];
    logic signed [DW-1:0] rdDataB [NB];
    logic [NB-1:0]        rdValidA, rdValidB;

    int checkCount;
    int errorCount;

    banked_fmap_ram #(
        .NUM_BANKS(NB), .A_WID(AW), .D_WID(DW),
        .RD_LAT(1), .WR_MODE(0), .INIT_ON_RESET(1)
    ) u_dut_a (
        .clk(clock), .rst_n(rstN), .clr_req(clrReq), .busy(busyA),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_valid(rdValidA)
    );

    banked_fmap_ram #(
        .NUM_BANKS(NB), .A_WID(AW), .D_WID(DW),
        .RD_LAT(2), .WR_MODE(1), .INIT_ON_RESET(1)
    ) u_dut_b (
        .clk(clock), .rst_n(rstN), .clr_req(clrReq), .busy(busyB),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_valid(rdValidB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock edge with the currently driven inputs; outputs settle 1ns later.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        clrReq = 1'b0;
        wrEn   = '0;
        rdEn   = '0;
        for (int b = 0; b < NB; b++) begin
            wrAddr[b] = '0;
            wrData[b] = '0;
            rdAddr[b] = '0;
        end
    endtask

    task automatic countBusy(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int n = 0; n < 40; n++) begin
            if (!busyA && !busyB) break;
            na += int'(busyA);
            nb += int'(busyB);
            applyStimulus();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nA, nB, nClr, stray, guard, nzA, nzB, vbad;
        checkCount = 0;
        errorCount = 0;
        idleInputs();
        rstN = 1'b1;
        #2 rstN = 1'b0;
        applyStimulus();
        applyStimulus();

        // Reset state: clear engine armed, read side quiet.
        checkOutput("rst_busy_a", busyA, 1);
        checkOutput("rst_busy_b", busyB, 1);
        checkOutput("rst_valid_a", rdValidA, 0);
        checkOutput("rst_valid_b", rdValidB, 0);
        checkOutput("rst_data_a0", rdDataA[0], 0);
        checkOutput("rst_data_b3", rdDataB[3], 0);

        rstN = 1'b1;
        countBusy(nA, nB);
        checkOutput("init_busy_cycles_a", nA, 16);
        checkOutput("init_busy_cycles_b", nB, 16);

        // Read bank 2 addr 9 after the initial clear.
        rdEn = 4'b0100;
        rdAddr[2] = 4'd9;
        applyStimulus();
        idleInputs();
        checkOutput("init_rd_valid_a", rdValidA, 4'b0100);
        checkOutput("init_rd_data_a", rdDataA[2], 0);
        checkOutput("init_rd_valid_b_early", rdValidB, 0);
        applyStimulus();
        checkOutput("init_rd_valid_b", rdValidB, 4'b0100);
        checkOutput("init_rd_data_b", rdDataB[2], 0);
        checkOutput("init_rd_valid_a_once", rdValidA, 0);

        // Independent banks: bank0 and bank3 written together, read together.
        wrEn = 4'b1001;
        wrAddr[0] = 4'd3; wrData[0] = 20'sd1000;
        wrAddr[3] = 4'd3; wrData[3] = -20'sd5;
        applyStimulus();
        idleInputs();
        rdEn = 4'b1001;
        rdAddr[0] = 4'd3;
        rdAddr[3] = 4'd3;
        applyStimulus();
        idleInputs();
        checkOutput("wr_rd_valid_a", rdValidA, 4'b1001);
        checkOutput("wr_rd_data_a0", rdDataA[0], 1000);
        checkOutput("wr_rd_data_a3", rdDataA[3], -5);
        applyStimulus();
        checkOutput("wr_rd_valid_b", rdValidB, 4'b1001);
        checkOutput("wr_rd_data_b0", rdDataB[0], 1000);
        checkOutput("wr_rd_data_b3", rdDataB[3], -5);
        checkOutput("wr_rd_valid_a_done", rdValidA, 0);

        // Streaming: fill bank1 addrs 0..7, then read them back-to-back.
        for (int k = 0; k < 8; k++) begin
            wrEn = 4'b0010;
            wrAddr[1] = AW'(k);
            wrData[1] = DW'(100 + k);
            applyStimulus();
        end
        idleInputs();
        for (int k = 0; k < 8; k++) begin
            rdEn = 4'b0010;
            rdAddr[1] = AW'(k);
            applyStimulus();
            checkOutput($sformatf("stream_valid_a_%0d", k), rdValidA, 4'b0010);
            checkOutput($sformatf("stream_data_a_%0d", k), rdDataA[1], 100 + k);
            checkOutput($sformatf("stream_valid_b_%0d", k), rdValidB, (k >= 1) ? 4'b0010 : 4'b0000);
            if (k >= 1) begin
                checkOutput($sformatf("stream_data_b_%0d", k), rdDataB[1], 100 + k - 1);
            end
        end
        idleInputs();
        applyStimulus();
        checkOutput("stream_valid_a_end", rdValidA, 0);
        checkOutput("stream_valid_b_last", rdValidB, 4'b0010);
        checkOutput("stream_data_b_last", rdDataB[1], 107);
        applyStimulus();
        checkOutput("stream_valid_b_end", rdValidB, 0);
        checkOutput("stream_hold_b", rdDataB[1], 107);

        // Collision on bank0 addr5: old 7, new 9.
        wrEn = 4'b0001; wrAddr[0] = 4'd5; wrData[0] = 20'sd7;
        applyStimulus();
        wrEn = 4'b0001; wrAddr[0] = 4'd5; wrData[0] = 20'sd9;
        rdEn = 4'b0001; rdAddr[0] = 4'd5;
        applyStimulus();
        idleInputs();
        checkOutput("coll_read_first_a", rdDataA[0], 7);
        applyStimulus();
        checkOutput("coll_write_first_b", rdDataB[0], 9);
        rdEn = 4'b0001; rdAddr[0] = 4'd5;
        applyStimulus();
        idleInputs();
        checkOutput("coll_after_a", rdDataA[0], 9);
        applyStimulus();
        checkOutput("coll_after_b", rdDataB[0], 9);

        // Clear during traffic.
        wrEn = 4'b0100; wrAddr[2] = 4'd4; wrData[2] = 20'sd321;
        applyStimulus();
        idleInputs();
        clrReq = 1'b1;
        rdEn = 4'b0100; rdAddr[2] = 4'd4;
        applyStimulus();
        nClr = int'(busyA);
        checkOutput("clr_busy_a", busyA, 1);
        checkOutput("clr_pre_valid_a", rdValidA, 4'b0100);
        checkOutput("clr_pre_data_a", rdDataA[2], 321);
        clrReq = 1'b0;
        rdEn = 4'hF;
        wrEn = 4'hF;
        for (int b = 0; b < NB; b++) begin
            rdAddr[b] = 4'd4;
            wrAddr[b] = 4'd0;
            wrData[b] = 20'sd999;
        end
        applyStimulus();
        nClr += int'(busyA);
        checkOutput("clr_pre_valid_b", rdValidB, 4'b0100);
        checkOutput("clr_pre_data_b", rdDataB[2], 321);
        checkOutput("clr_rd_ignored_a", rdValidA, 0);
        stray = 0;
        guard = 0;
        while (busyA && guard < 40) begin
            clrReq = (nClr == 8);
            applyStimulus();
            if (rdValidA != 0 || rdValidB != 0) stray++;
            nClr += int'(busyA);
            guard++;
        end
        idleInputs();
        checkOutput("clr_busy_cycles", nClr, 16);
        checkOutput("clr_busy_b_done", busyB, 0);
        checkOutput("clr_no_valid", stray, 0);

        nzA = 0; nzB = 0; vbad = 0;
        for (int a = 0; a < 16; a++) begin
            rdEn = 4'hF;
            for (int b = 0; b < NB; b++) rdAddr[b] = AW'(a);
            applyStimulus();
            if (rdValidA != 4'hF) vbad++;
            if (a >= 1 && rdValidB != 4'hF) vbad++;
            for (int b = 0; b < NB; b++) begin
                if (rdDataA[b] !== 0) nzA++;
                if (a >= 1 && rdDataB[b] !== 0) nzB++;
            end
        end
        idleInputs();
        applyStimulus();
        if (rdValidB != 4'hF) vbad++;
        for (int b = 0; b < NB; b++) if (rdDataB[b] !== 0) nzB++;
        checkOutput("clr_zero_words_a", nzA, 0);
        checkOutput("clr_zero_words_b", nzB, 0);
        checkOutput("clr_sweep_valids", vbad, 0);

        // Reset in the middle of a clear.
        wrEn = 4'b1000; wrAddr[3] = 4'd1; wrData[3] = -20'sd77;
        applyStimulus();
        idleInputs();
        clrReq = 1'b1;
        rdEn = 4'b1000; rdAddr[3] = 4'd1;
        applyStimulus();
        idleInputs();
        checkOutput("mid_pre_data_a", rdDataA[3], -77);
        applyStimulus();
        checkOutput("mid_pre_data_b", rdDataB[3], -77);
        for (int k = 0; k < 9; k++) applyStimulus();
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_valid_a", rdValidA, 0);
        checkOutput("mid_rst_valid_b", rdValidB, 0);
        checkOutput("mid_rst_data_a", rdDataA[3], 0);
        checkOutput("mid_rst_data_b", rdDataB[3], 0);
        checkOutput("mid_rst_busy_a", busyA, 1);
        applyStimulus();
        rstN = 1'b1;
        countBusy(nA, nB);
        checkOutput("mid_busy_cycles_a", nA, 16);
        checkOutput("mid_busy_cycles_b", nB, 16);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
